vga_frame_reader: RTL and testbench
===================================

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter H_RES, default 640: pixels per line.
REQ-002 Parameter V_RES, default 480: lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, power of 2, at least 4: pixel buffer entries.
REQ-004 Parameter DEFAULT_BASE, default 32'h0000_0000: frame base byte address used after reset.
REQ-005 clk  in  1  single clock, shared with the SDRAM controller and VGA subsystem.
REQ-006 reset  in  1  reset, synchronous and active-high.
REQ-007 enable  in  1  level; frames are fetched while high.
REQ-008 buffer_base  in  32  byte address of the next frame (RGB565, 2 bytes per pixel).
REQ-009 base_load  in  1  one-cycle strobe; captures buffer_base into the pending base.
REQ-010 avm_address  out  32  Avalon-MM read byte address.
REQ-011 avm_read  out  1  read request.
REQ-012 avm_waitrequest  in  1  slave stall.
REQ-013 avm_readdata  in  16  RGB565 pixel.
REQ-014 avm_readdatavalid  in  1  read data strobe.
REQ-015 aso_data  out  24  {R8,G8,B8} pixel to the VGA pixel stream.
REQ-016 aso_valid  out  1  stream valid.
REQ-017 aso_ready  in  1  stream ready.
REQ-018 aso_startofpacket  out  1  first pixel of a frame.
REQ-019 aso_endofpacket  out  1  last pixel of a frame.
REQ-020 frame_done  out  1  one-cycle pulse when the last pixel is accepted.

Function
REQ-021 The FSM SHALL have three states: IDLE, FETCH and DRAIN.
REQ-022 IDLE->FETCH when enable=1; this transition SHALL latch the pending base into the active frame base and clear the counters.
REQ-023 avm_read SHALL assert in the first FETCH cycle.
REQ-024 avm_address SHALL equal the active frame base plus twice the request index.
REQ-025 avm_read/avm_address SHALL hold stable while avm_waitrequest=1; a request counts as issued only on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-026 Credit rule: a new read SHALL be issued only when outstanding reads plus FIFO occupancy < FIFO_DEPTH, so the FIFO never overflows.
REQ-027 FETCH->DRAIN after request H_RES*V_RES-1 is issued.
REQ-028 DRAIN->IDLE, with frame_done=1 for exactly one cycle, on the cycle the EOP pixel is accepted (aso_valid & aso_ready).
REQ-029 From IDLE after frame_done, if enable=1 the next frame SHALL start on the following cycle (back-to-back frames).
REQ-030 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame always completes.
REQ-031 base_load in any state SHALL update only the pending base, never the active frame (tear-free swap); base_load coincident with the frame-start latch SHALL pass the new value through.
REQ-032 Outstanding counter: +1 on issue, -1 on avm_readdatavalid, both in the same cycle gives net 0; avm_readdatavalid with outstanding=0 SHALL be discarded.
REQ-033 Each accepted avm_readdata SHALL be written to the FIFO.
REQ-034 aso_valid SHALL be high whenever the FIFO is non-empty; FIFO latency write-to-aso_valid is 1 cycle.
REQ-035 Pop on aso_valid & aso_ready; simultaneous push and pop on a full or empty FIFO SHALL be handled correctly (occupancy unchanged).
REQ-036 Colour expansion: R8={r5,r5[4:2]}, G8={g6,g6[5:4]}, B8={b5,b5[4:2]}.
REQ-037 aso_startofpacket SHALL be high with pixel 0 of the frame, and aso_endofpacket high with pixel H_RES*V_RES-1; both track the output pixel counter, not the request counter.
REQ-038 aso_data, aso_valid, SOP and EOP SHALL hold stable while aso_ready=0.
REQ-039 The request counter and the output counter SHALL each be ceil(log2(H_RES*V_RES)) bits and wrap to 0 at the frame start.

Reset
REQ-040 On reset: state=IDLE; avm_read=0; avm_address=0; aso_valid=0; SOP=EOP=0; frame_done=0; FIFO empty; counters=0; pending base=DEFAULT_BASE.
REQ-041 Reset mid-frame SHALL abandon the frame immediately; read data still arriving is discarded per REQ-032.

Structure
REQ-042 Package vga_frame_reader_pkg SHALL hold the state encoding, the RGB565-to-888 expansion function and the pixel width constants.
REQ-043 One sub-module, pixel_fifo (synchronous, show-ahead, parameterised width and depth), SHALL be instantiated.

Verification (H_RES=4, V_RES=2, FIFO_DEPTH=4, DEFAULT_BASE=32'h100)
REQ-044 enable=1, zero waitrequest, readdatavalid 2 cycles after issue, aso_ready=1 -> addresses 0x100..0x10E, 8 pixels, SOP on pixel 0, EOP on pixel 7, one frame_done pulse.
REQ-045 aso_ready=0 for 20 cycles -> at most 4 reads outstanding plus buffered, no FIFO overflow, aso_data stable.
REQ-046 avm_waitrequest=1 for 3 cycles on request 2 -> address 0x104 held, no duplicate or skipped address.
REQ-047 readdata 16'hF800 -> aso_data 24'hFF0000; 16'h07E0 -> 24'h00FF00; 16'h001F -> 24'h0000FF.
REQ-048 base_load of 32'h200 mid-frame -> current frame completes at 0x10x; next frame starts at 0x200.
REQ-049 reset at pixel 3, then enable -> new frame starts at the pending base with a fresh SOP; stale readdatavalid is dropped.

Source files
------------

// File: rtl/vga_frame_reader_pkg.sv
// Shared types for the VGA frame reader: FSM state, pixel widths
// and the RGB565 to RGB888 colour expansion.
package vga_frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PIX_IN_W  = 16;
  localparam int PIX_OUT_W = 24;

  // Low channel bits are refilled from the MSBs so that
  // full-scale 565 values map to full-scale 888 values.
  function automatic logic [PIX_OUT_W-1:0] rgb565_to_888(
    input logic [PIX_IN_W-1:0] p
  );
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

endpackage

// File: rtl/vga_frame_reader_fifo.sv
// pixel_fifo: synchronous show-ahead FIFO. Ports: clk, reset,
// push/wdata, pop, rdata (head entry), empty, count.
module pixel_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign rdata = mem[rd_ptr];

  // A pop frees the head slot this cycle, so a push into a
  // full FIFO is allowed when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Streams RGB565 frames from Avalon-MM memory to a 24-bit pixel
// stream with SOP/EOP. Ports: enable, buffer_base/base_load,
// avm_* read master, aso_* stream source, frame_done pulse.
module vga_frame_reader
  import vga_frame_reader_pkg::*;
#(
  parameter int          H_RES        = 640,
  parameter int          V_RES        = 480,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] DEFAULT_BASE = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [31:0]          buffer_base,
  input  logic                 base_load,
  output logic [31:0]          avm_address,
  output logic                 avm_read,
  input  logic                 avm_waitrequest,
  input  logic [PIX_IN_W-1:0]  avm_readdata,
  input  logic                 avm_readdatavalid,
  output logic [PIX_OUT_W-1:0] aso_data,
  output logic                 aso_valid,
  input  logic                 aso_ready,
  output logic                 aso_startofpacket,
  output logic                 aso_endofpacket,
  output logic                 frame_done
);

  localparam int N_PIX = H_RES * V_RES;
  localparam int CW    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int FW    = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] LAST   = CW'(N_PIX - 1);
  localparam logic [FW+1:0] CREDIT = (FW+2)'(FIFO_DEPTH);

  state_t              state;
  logic [31:0]         pending_base;
  logic [31:0]         active_base;
  logic [31:0]         start_base;
  logic [CW-1:0]       req_cnt;
  logic [CW-1:0]       req_nxt;
  logic [CW-1:0]       out_cnt;
  logic [FW:0]         outstanding;
  logic [FW:0]         f_count;
  logic                f_empty;
  logic [PIX_IN_W-1:0] f_rdata;
  logic                issue;
  logic                rd_ok;
  logic                pop;
  logic [FW+1:0]       used_nxt;
  logic                credit_ok;

  assign issue = avm_read && !avm_waitrequest;
  // Data with nothing outstanding is stale (e.g. from before a
  // reset) and is dropped.
  assign rd_ok = avm_readdatavalid && (outstanding != '0);
  assign pop   = aso_valid && aso_ready;

  assign aso_valid         = !f_empty;
  assign aso_data          = rgb565_to_888(f_rdata);
  assign aso_startofpacket = aso_valid && (out_cnt == '0);
  assign aso_endofpacket   = aso_valid && (out_cnt == LAST);
  assign frame_done        = pop && aso_endofpacket;

  assign start_base = base_load ? buffer_base : pending_base;
  assign req_nxt    = req_cnt + CW'(1);

  // Slots committed after this edge: in flight plus buffered.
  // A returning read moves one slot from in-flight to buffered,
  // so it does not change the total.
  assign used_nxt  = (FW+2)'(outstanding) + (FW+2)'(f_count)
                   + (FW+2)'(issue) - (FW+2)'(pop);
  assign credit_ok = (used_nxt < CREDIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      avm_read     <= 1'b0;
      avm_address  <= '0;
      active_base  <= '0;
      pending_base <= DEFAULT_BASE;
      req_cnt      <= '0;
      out_cnt      <= '0;
      outstanding  <= '0;
    end else begin
      if (base_load) pending_base <= buffer_base;
      outstanding <= outstanding + (FW+1)'(issue)
                                 - (FW+1)'(rd_ok);
      if (pop) out_cnt <= out_cnt + CW'(1);
      unique case (state)
        IDLE: begin
          if (enable) begin
            active_base <= start_base;
            avm_address <= start_base;
            avm_read    <= 1'b1;
            req_cnt     <= '0;
            out_cnt     <= '0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            if (req_cnt == LAST) begin
              avm_read <= 1'b0;
              state    <= DRAIN;
            end else begin
              req_cnt     <= req_nxt;
              avm_address <= active_base
                           + (32'(req_nxt) << 1);
              avm_read    <= credit_ok;
            end
          end else if (!avm_read) begin
            avm_read <= credit_ok;
          end
        end
        DRAIN: begin
          if (frame_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pixel_fifo #(
    .WIDTH (PIX_IN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_ok),
    .wdata (avm_readdata),
    .pop   (pop),
    .rdata (f_rdata),
    .empty (f_empty),
    .count (f_count)
  );

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomised bench for vga_frame_reader with a memory/stream
// reference model; H_RES=4, V_RES=2, FIFO_DEPTH=4, base 0x100.
module tb_vga_frame_reader;

  localparam int          H_RES = 4;
  localparam int          V_RES = 2;
  localparam int          DEPTH = 4;
  localparam int          NPIX  = H_RES * V_RES;
  localparam logic [31:0] DEF_B = 32'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] buffer_base = '0;
  logic        base_load = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [15:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [23:0] aso_data;
  logic        aso_valid;
  logic        aso_ready = 1'b1;
  logic        aso_startofpacket;
  logic        aso_endofpacket;
  logic        frame_done;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .H_RES        (H_RES),
    .V_RES        (V_RES),
    .FIFO_DEPTH   (DEPTH),
    .DEFAULT_BASE (DEF_B)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .buffer_base       (buffer_base),
    .base_load         (base_load),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .aso_data          (aso_data),
    .aso_valid         (aso_valid),
    .aso_ready         (aso_ready),
    .aso_startofpacket (aso_startofpacket),
    .aso_endofpacket   (aso_endofpacket),
    .frame_done        (frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  logic [15:0] mem16 [512];

  function automatic logic [15:0] mem_of(input logic [31:0] a);
    return mem16[a[9:1]];
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16),
            8'(b * 8 + b / 4)};
  endfunction

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  rd_t         sq[$];
  logic [31:0] fbase[$];
  int          cyc = 0;
  int          iss_f = 0, iss_idx = 0;
  int          out_f = 0, out_idx = 0;
  int          model_out = 0, buffered = 0;
  int          done_cnt = 0;
  bit          rand_wr = 0, rand_rdy = 0;
  bit          arm_stall = 0;
  int          stall_left = 0, hold_ready = 0;
  logic [31:0] stall_addr = '0;

  logic        p_valid = 0, p_ready = 0, p_sop = 0, p_eop = 0;
  logic        p_read = 0, p_wait = 0;
  logic [23:0] p_data = '0;
  logic [31:0] p_addr = '0;
  logic [31:0] exp_addr;
  logic [31:0] pix_addr;
  bit          exp_done;

  // Memory slave and stream sink.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (sq.size() != 0 && sq[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = sq[0].data;
      sq.delete(0);
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 16'($urandom);
    end
    if (stall_left > 0) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else if (arm_stall && avm_read &&
                 avm_address == stall_addr) begin
      arm_stall       = 0;
      avm_waitrequest = 1'b1;
      stall_left      = 2;
    end else begin
      avm_waitrequest = rand_wr && ($urandom_range(3) == 0);
    end
    if (hold_ready > 0) begin
      aso_ready = 1'b0;
      hold_ready--;
    end else begin
      aso_ready = !rand_rdy || ($urandom_range(3) != 0);
    end
  end

  // Reference model: frame k reads fbase[k] + 2*i and emits
  // expand(mem) in order with SOP at i=0 and EOP at i=NPIX-1.
  always @(negedge clk) begin
    if (reset) begin
      fbase.delete();
      iss_f = 0; iss_idx = 0;
      out_f = 0; out_idx = 0;
      model_out = 0; buffered = 0;
      p_valid = 0; p_read = 0;
    end else begin
      exp_done = 0;
      if (p_valid && !p_ready) begin
        check_eq("hold_valid", aso_valid, 1);
        check_eq("hold_data", aso_data, p_data);
        check_eq("hold_sop", aso_startofpacket, p_sop);
        check_eq("hold_eop", aso_endofpacket, p_eop);
      end
      if (p_read && p_wait) begin
        check_eq("hold_read", avm_read, 1);
        check_eq("hold_addr", avm_address, p_addr);
      end
      check_eq("valid_vs_fill", aso_valid, buffered != 0);
      if (avm_readdatavalid && model_out > 0) begin
        model_out--;
        buffered++;
      end
      if (avm_read && !avm_waitrequest) begin
        exp_addr = (iss_f < fbase.size())
                 ? fbase[iss_f] + 32'(2 * iss_idx)
                 : 32'hDEAD_BEEF;
        check_eq("req_addr", avm_address, exp_addr);
        sq.push_back('{cyc + 2, mem_of(avm_address)});
        model_out++;
        iss_idx++;
        if (iss_idx == NPIX) begin
          iss_idx = 0;
          iss_f++;
        end
      end
      if (aso_valid && aso_ready) begin
        pix_addr = (out_f < fbase.size())
                 ? fbase[out_f] + 32'(2 * out_idx)
                 : 32'hDEAD_BEEF;
        check_eq("pix_data", aso_data, expand(mem_of(pix_addr)));
        check_eq("pix_sop", aso_startofpacket, out_idx == 0);
        check_eq("pix_eop", aso_endofpacket,
                 out_idx == NPIX - 1);
        if (buffered > 0) buffered--;
        out_idx++;
        if (out_idx == NPIX) begin
          out_idx  = 0;
          out_f++;
          exp_done = 1;
        end
      end
      check_eq("frame_done", frame_done, exp_done);
      if (frame_done) done_cnt++;
      check_eq("credit", (model_out + buffered) <= DEPTH, 1);
      p_valid = aso_valid;
      p_ready = aso_ready;
      p_data  = aso_data;
      p_sop   = aso_startofpacket;
      p_eop   = aso_endofpacket;
      p_read  = avm_read;
      p_wait  = avm_waitrequest;
      p_addr  = avm_address;
    end
  end

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_timeout", done_cnt >= target, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_read"}, avm_read, 0);
    check_eq({tag, "_addr"}, avm_address, 0);
    check_eq({tag, "_valid"}, aso_valid, 0);
    check_eq({tag, "_sop"}, aso_startofpacket, 0);
    check_eq({tag, "_eop"}, aso_endofpacket, 0);
    check_eq({tag, "_done"}, frame_done, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 512; i++) mem16[i] = 16'($urandom);
    mem16[9'h080] = 16'hF800;
    mem16[9'h081] = 16'h07E0;
    mem16[9'h082] = 16'h001F;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Two back-to-back frames at the default base, a 3-cycle
    // stall on 0x104 and 20 cycles of sink backpressure.
    fbase.push_back(DEF_B);
    fbase.push_back(DEF_B);
    stall_addr = 32'h104;
    arm_stall  = 1;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_done(1, 200);
    hold_ready = 20;
    wait_done(2, 300);
    enable = 1'b0;
    check_eq("stall_used", arm_stall, 0);

    // Random stalls; base swap to 0x200 mid-frame.
    repeat (5) @(posedge clk);
    rand_wr  = 1;
    rand_rdy = 1;
    fbase.push_back(DEF_B);
    fbase.push_back(32'h200);
    @(posedge clk);
    #1 enable = 1'b1;
    n = 0;
    while (!(iss_f == 2 && iss_idx >= 3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("swap_timeout", n < 200, 1);
    @(posedge clk);
    #1;
    buffer_base = 32'h200;
    base_load   = 1'b1;
    @(posedge clk);
    #1 base_load = 1'b0;
    wait_done(4, 400);
    enable = 1'b0;

    // Reset around pixel 3 of a frame at 0x200.
    repeat (3) @(posedge clk);
    fbase.push_back(32'h200);
    @(posedge clk);
    #1 enable = 1'b1;
    n = 0;
    while (!(out_f == 4 && out_idx >= 3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("pix3_timeout", n < 200, 1);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    n = 0;
    while (sq.size() != 0 && n < 50) begin
      @(negedge clk);
      check_eq("stale_drop", aso_valid, 0);
      n++;
    end
    repeat (2) @(negedge clk);
    check_eq("stale_empty", aso_valid, 0);

    // Fresh frame at the restored default base, then a frame
    // whose base_load coincides with the start.
    fbase.push_back(DEF_B);
    fbase.push_back(32'h300);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_done(5, 300);
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable      = 1'b1;
    buffer_base = 32'h300;
    base_load   = 1'b1;
    @(posedge clk);
    #1 base_load = 1'b0;
    wait_done(6, 300);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("frames_seen", out_f, 2);
    check_eq("end_valid", aso_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
